mycpu_wb_stage: RTL and testbench
=================================

MYCPU_WB_STAGE -- requirements
Module: mycpu_wb_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register/data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register-number width.
REQ-003 SHALL have clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ms_to_ws_valid  in  1  memory stage presents an instruction.
REQ-006 SHALL have ws_allowin  out  1  stage can accept this cycle.
REQ-007 SHALL have ms_pc  in  32  instruction PC.
REQ-008 SHALL have ms_gr_we  in  1  instruction writes a GPR.
REQ-009 SHALL have ms_dest  in  ADDR_WIDTH  destination register.
REQ-010 SHALL have ms_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
REQ-011 SHALL have ms_addr_lo  in  2  load address bits [1:0].
REQ-012 SHALL have ms_result  in  DATA_WIDTH  ALU result, or raw memory word for loads.
REQ-013 SHALL have wb_stall  in  1  hold the instruction in WB.
REQ-014 SHALL have rf_wen/rf_waddr/rf_wdata  out  4/ADDR_WIDTH/DATA_WIDTH  per-byte register-file write port; bit i writes byte i.
REQ-015 SHALL have ws_fwd_valid/ws_fwd_dest/ws_fwd_data  out  1/ADDR_WIDTH/DATA_WIDTH  bypass to decode.
REQ-016 SHALL have debug_wb_pc/debug_wb_rf_wen/debug_wb_rf_wnum/debug_wb_rf_wdata  out  32/4/ADDR_WIDTH/DATA_WIDTH  trace port, mirroring the rf_* outputs.

Function
REQ-017 SHALL hold a single pipeline register with ws_valid; ws_ready_go = !wb_stall; ws_allowin = !ws_valid || ws_ready_go.
REQ-018 SHALL capture the ms_* fields, and set ws_valid=1, at the edge where ms_to_ws_valid && ws_allowin; SHALL clear ws_valid at a retiring edge with no new input.
REQ-019 SHALL accept and retire in the same cycle when valid, not stalled and fed, giving back-to-back throughput of one instruction per cycle.
REQ-020 SHALL assert rf_wen only in the retire cycle (ws_valid && ws_ready_go && gr_we && dest!=0), one cycle after capture; otherwise rf_wen=0.
REQ-021 SHALL, while stalled, hold all captured fields stable and keep rf_wen=0.
REQ-022 SHALL produce rf_wdata for load_op 0 as result; LB/LBU as byte[addr_lo] sign/zero-extended; LH/LHU as half[addr_lo[1]] sign/zero-extended; LW as the full word, with addr_lo ignored.
REQ-023 SHALL use rf_wen=4'b1111 for load_op 0–5.
REQ-024 SHALL produce rf_wdata for LWL as word << 8*(3-addr_lo), with rf_wen 1000/1100/1110/1111 for addr_lo 0/1/2/3.
REQ-025 SHALL produce rf_wdata for LWR as word >> 8*addr_lo, with rf_wen 1111/0111/0011/0001 for addr_lo 0/1/2/3.
REQ-026 SHALL drive ws_fwd_valid = ws_valid && gr_we && dest!=0 (including during stall) and ws_fwd_data = aligned rf_wdata.
REQ-027 SHALL drive debug_wb_rf_wen equal to rf_wen every cycle; other debug fields from the stage register.

Reset
REQ-028 SHALL, at a reset edge, clear ws_valid and all captured fields to 0; all outputs read 0 except ws_allowin=1.
REQ-029 SHALL discard an instruction in WB when reset occurs mid-operation: no rf_wen in the reset cycle and no write after it.

Configuration
REQ-030 SHALL implement LWL/LWR handling (REQ-024/025) only when MYCPU_UNALIGNED_LOAD_EN is defined.
REQ-031 SHALL, without MYCPU_UNALIGNED_LOAD_EN, retire load_op 6/7 with rf_wen=0 and ws_fwd_valid=0.

Structure
REQ-032 SHALL take the load_op encoding, the width constants and the byte-enable patterns from shared package mycpu_pkg.
REQ-033 SHALL place data/byte-enable alignment in a combinational sub-module mycpu_load_align.

Verification
REQ-034 SHALL cover: ALU op, dest=3, result 0x12345678 -> next cycle rf_wen=1111, rf_wdata=0x12345678.
REQ-035 SHALL cover: LB and LBU, word 0x80FF7F01, addr_lo=1 -> 0x0000007F for both; LB addr_lo=2 -> 0xFFFFFFFF; LHU addr_lo=2 -> 0x000080FF.
REQ-036 SHALL cover: LWL addr_lo=1, word 0xAABBCCDD -> rf_wen=1100, rf_wdata[31:16]=0xCCDD; LWR addr_lo=2 -> rf_wen=0011, rf_wdata[15:0]=0xAABB.
REQ-037 SHALL cover: dest=0 with gr_we=1 -> rf_wen=0, ws_fwd_valid=0.
REQ-038 SHALL cover: wb_stall high 3 cycles with a second instruction offered -> ws_allowin=0, rf_wen=0, fields held; after release, both retire on consecutive cycles in order.
REQ-039 SHALL cover: rst asserted while ws_valid=1 -> no write that cycle or after; ws_allowin=1.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu writeback slice: widths, load-op encoding,
// and register-file byte-enable patterns (including the LWL/LWR partial-write masks).
package mycpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int PC_W   = 32;
   localparam int BE_W   = 4;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0,
      LOAD_LB   = 3'd1,
      LOAD_LBU  = 3'd2,
      LOAD_LH   = 3'd3,
      LOAD_LHU  = 3'd4,
      LOAD_LW   = 3'd5,
      LOAD_LWL  = 3'd6,
      LOAD_LWR  = 3'd7
   } load_op_e;

   localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
   localparam logic [BE_W-1:0] BE_ALL  = 4'b1111;

   // LWL fills from the top byte down; LWR fills from the bottom byte up.
   function automatic logic [BE_W-1:0] lwl_be(input logic [1:0] addr_lo);
      case (addr_lo)
         2'd0:    lwl_be = 4'b1000;
         2'd1:    lwl_be = 4'b1100;
         2'd2:    lwl_be = 4'b1110;
         default: lwl_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [BE_W-1:0] lwr_be(input logic [1:0] addr_lo);
      case (addr_lo)
         2'd0:    lwr_be = 4'b1111;
         2'd1:    lwr_be = 4'b0111;
         2'd2:    lwr_be = 4'b0011;
         default: lwr_be = 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/mycpu_load_align.sv
// Combinational load data alignment and byte-enable generation for writeback.
// LWL/LWR merging is built only with MYCPU_UNALIGNED_LOAD_EN; otherwise they produce no write.
module mycpu_load_align
   import mycpu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W
) (
   input  logic [2:0]            load_op,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] data,
   output logic [BE_W-1:0]       be
);

   logic [DATA_WIDTH-1:0] word_shr;
   logic [7:0]            sel_byte;
   logic [15:0]           sel_half;

   always_comb begin
      word_shr = word >> {addr_lo, 3'b000};
      sel_byte = word_shr[7:0];
      sel_half = addr_lo[1] ? word[31:16] : word[15:0];
      data     = word;
      be       = BE_ALL;
      case (load_op_e'(load_op))
         LOAD_LB:  data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
         LOAD_LBU: data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
         LOAD_LH:  data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
         LOAD_LHU: data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
`ifdef MYCPU_UNALIGNED_LOAD_EN
         // ~addr_lo equals 3-addr_lo for a 2-bit offset.
         LOAD_LWL: begin
            data = word << {~addr_lo, 3'b000};
            be   = lwl_be(addr_lo);
         end
         LOAD_LWR: begin
            data = word_shr;
            be   = lwr_be(addr_lo);
         end
`else
         LOAD_LWL: be = BE_NONE;
         LOAD_LWR: be = BE_NONE;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mycpu_wb_stage.sv
// Writeback stage: one pipeline register, per-byte register-file write, decode bypass, trace port.
// Optional LWL/LWR support is enabled by defining MYCPU_UNALIGNED_LOAD_EN.
module mycpu_wb_stage
   import mycpu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ms_to_ws_valid,
   output logic                  ws_allowin,
   input  logic [31:0]           ms_pc,
   input  logic                  ms_gr_we,
   input  logic [ADDR_WIDTH-1:0] ms_dest,
   input  logic [2:0]            ms_load_op,
   input  logic [1:0]            ms_addr_lo,
   input  logic [DATA_WIDTH-1:0] ms_result,
   input  logic                  wb_stall,
   output logic [3:0]            rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  ws_fwd_valid,
   output logic [ADDR_WIDTH-1:0] ws_fwd_dest,
   output logic [DATA_WIDTH-1:0] ws_fwd_data,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
   output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata
);

   logic                  ws_valid_q,   ws_valid_d;
   logic [31:0]           pc_q,         pc_d;
   logic                  gr_we_q,      gr_we_d;
   logic [ADDR_WIDTH-1:0] dest_q,       dest_d;
   logic [2:0]            load_op_q,    load_op_d;
   logic [1:0]            addr_lo_q,    addr_lo_d;
   logic [DATA_WIDTH-1:0] result_q,     result_d;

   logic                  ws_ready_go;
   logic                  accept;
   logic                  writes_gpr;
   logic [DATA_WIDTH-1:0] align_data;
   logic [BE_W-1:0]       align_be;

   mycpu_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .load_op (load_op_q),
      .addr_lo (addr_lo_q),
      .word    (result_q),
      .data    (align_data),
      .be      (align_be)
   );

   always_comb begin
      ws_ready_go = !wb_stall;
      ws_allowin  = !ws_valid_q || ws_ready_go;
      accept      = ms_to_ws_valid && ws_allowin;

      ws_valid_d = ws_valid_q;
      pc_d       = pc_q;
      gr_we_d    = gr_we_q;
      dest_d     = dest_q;
      load_op_d  = load_op_q;
      addr_lo_d  = addr_lo_q;
      result_d   = result_q;
      if (accept) begin
         ws_valid_d = 1'b1;
         pc_d       = ms_pc;
         gr_we_d    = ms_gr_we;
         dest_d     = ms_dest;
         load_op_d  = ms_load_op;
         addr_lo_d  = ms_addr_lo;
         result_d   = ms_result;
      end else if (ws_ready_go) begin
         ws_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ws_valid_q <= 1'b0;
         pc_q       <= '0;
         gr_we_q    <= 1'b0;
         dest_q     <= '0;
         load_op_q  <= '0;
         addr_lo_q  <= '0;
         result_q   <= '0;
      end else begin
         ws_valid_q <= ws_valid_d;
         pc_q       <= pc_d;
         gr_we_q    <= gr_we_d;
         dest_q     <= dest_d;
         load_op_q  <= load_op_d;
         addr_lo_q  <= addr_lo_d;
         result_q   <= result_d;
      end
   end

   // A load with an empty byte mask (LWL/LWR when unsupported) neither writes nor forwards.
   always_comb begin
      writes_gpr   = gr_we_q && (dest_q != '0) && (align_be != BE_NONE);
      rf_wen       = (ws_valid_q && ws_ready_go && writes_gpr && !rst) ? align_be : BE_NONE;
      rf_waddr     = dest_q;
      rf_wdata     = align_data;
      ws_fwd_valid = ws_valid_q && writes_gpr;
      ws_fwd_dest  = dest_q;
      ws_fwd_data  = align_data;
   end

   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_wen   = rf_wen;
   assign debug_wb_rf_wnum  = dest_q;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_mycpu_wb_stage.sv
// Directed bench for mycpu_wb_stage: vector table for alignment, hand sequences for stall and reset.
module tb_mycpu_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [2:0]  ms_load_op;
   logic [1:0]  ms_addr_lo;
   logic [31:0] ms_result;
   logic        wb_stall;
   logic [3:0]  rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        ws_fwd_valid;
   logic [4:0]  ws_fwd_dest;
   logic [31:0] ws_fwd_data;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mycpu_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk               (clk),
      .rst               (rst),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ws_allowin        (ws_allowin),
      .ms_pc             (ms_pc),
      .ms_gr_we          (ms_gr_we),
      .ms_dest           (ms_dest),
      .ms_load_op        (ms_load_op),
      .ms_addr_lo        (ms_addr_lo),
      .ms_result         (ms_result),
      .wb_stall          (wb_stall),
      .rf_wen            (rf_wen),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .ws_fwd_valid      (ws_fwd_valid),
      .ws_fwd_dest       (ws_fwd_dest),
      .ws_fwd_data       (ws_fwd_data),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  lo;
      logic [31:0] word;
      logic [4:0]  dest;
      logic        gr_we;
      logic [3:0]  exp_wen;
      logic [31:0] exp_wdata;
      logic        chk_data;
      logic        exp_fwd;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] word,
                               input logic [4:0] dest, input logic gr_we, input logic [3:0] wen,
                               input logic [31:0] wdata, input logic chk_data, input logic fwd);
      vec_t v;
      v.op = op; v.lo = lo; v.word = word; v.dest = dest; v.gr_we = gr_we;
      v.exp_wen = wen; v.exp_wdata = wdata; v.chk_data = chk_data; v.exp_fwd = fwd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                              input logic [2:0] op, input logic [1:0] lo, input logic [31:0] word);
      ms_to_ws_valid = 1'b1;
      ms_pc          = pc;
      ms_gr_we       = gr_we;
      ms_dest        = dest;
      ms_load_op     = op;
      ms_addr_lo     = lo;
      ms_result      = word;
   endtask

   task automatic idle_input();
      ms_to_ws_valid = 1'b0;
      ms_pc          = 32'hDEAD_BEEF;
      ms_gr_we       = 1'b1;
      ms_dest        = 5'd31;
      ms_load_op     = 3'd0;
      ms_addr_lo     = 2'd0;
      ms_result      = 32'h5555_AAAA;
   endtask

   initial begin
      rst      = 1'b1;
      wb_stall = 1'b0;
      idle_input();

      // word 0x80FF7F01: byte0=01 byte1=7F byte2=FF byte3=80
      vecs[0]  = mk(3'd0, 2'd0, 32'h1234_5678, 5'd3,  1'b1, 4'b1111, 32'h1234_5678, 1'b1, 1'b1);
      vecs[1]  = mk(3'd1, 2'd1, 32'h80FF_7F01, 5'd4,  1'b1, 4'b1111, 32'h0000_007F, 1'b1, 1'b1);
      vecs[2]  = mk(3'd2, 2'd1, 32'h80FF_7F01, 5'd4,  1'b1, 4'b1111, 32'h0000_007F, 1'b1, 1'b1);
      vecs[3]  = mk(3'd1, 2'd2, 32'h80FF_7F01, 5'd5,  1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b1);
      vecs[4]  = mk(3'd4, 2'd2, 32'h80FF_7F01, 5'd6,  1'b1, 4'b1111, 32'h0000_80FF, 1'b1, 1'b1);
      vecs[5]  = mk(3'd3, 2'd2, 32'h80FF_7F01, 5'd6,  1'b1, 4'b1111, 32'hFFFF_80FF, 1'b1, 1'b1);
      vecs[6]  = mk(3'd3, 2'd0, 32'h80FF_7F01, 5'd7,  1'b1, 4'b1111, 32'h0000_7F01, 1'b1, 1'b1);
      vecs[7]  = mk(3'd2, 2'd3, 32'h80FF_7F01, 5'd8,  1'b1, 4'b1111, 32'h0000_0080, 1'b1, 1'b1);
      vecs[8]  = mk(3'd1, 2'd0, 32'h80FF_7F01, 5'd8,  1'b1, 4'b1111, 32'h0000_0001, 1'b1, 1'b1);
      vecs[9]  = mk(3'd5, 2'd2, 32'h80FF_7F01, 5'd9,  1'b1, 4'b1111, 32'h80FF_7F01, 1'b1, 1'b1);
      vecs[10] = mk(3'd0, 2'd0, 32'hCAFE_F00D, 5'd0,  1'b1, 4'b0000, 32'hCAFE_F00D, 1'b1, 1'b0);
      vecs[11] = mk(3'd0, 2'd0, 32'h0BAD_F00D, 5'd10, 1'b0, 4'b0000, 32'h0BAD_F00D, 1'b1, 1'b0);
`ifdef MYCPU_UNALIGNED_LOAD_EN
      vecs[12] = mk(3'd6, 2'd1, 32'hAABB_CCDD, 5'd11, 1'b1, 4'b1100, 32'hCCDD_0000, 1'b1, 1'b1);
      vecs[13] = mk(3'd7, 2'd2, 32'hAABB_CCDD, 5'd12, 1'b1, 4'b0011, 32'h0000_AABB, 1'b1, 1'b1);
      vecs[14] = mk(3'd6, 2'd0, 32'hAABB_CCDD, 5'd13, 1'b1, 4'b1000, 32'hDD00_0000, 1'b1, 1'b1);
      vecs[15] = mk(3'd7, 2'd3, 32'hAABB_CCDD, 5'd14, 1'b1, 4'b0001, 32'h0000_00AA, 1'b1, 1'b1);
      vecs[16] = mk(3'd6, 2'd3, 32'hAABB_CCDD, 5'd15, 1'b1, 4'b1111, 32'hAABB_CCDD, 1'b1, 1'b1);
`else
      vecs[12] = mk(3'd6, 2'd1, 32'hAABB_CCDD, 5'd11, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
      vecs[13] = mk(3'd7, 2'd2, 32'hAABB_CCDD, 5'd12, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
      vecs[14] = mk(3'd6, 2'd0, 32'hAABB_CCDD, 5'd13, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
      vecs[15] = mk(3'd7, 2'd3, 32'hAABB_CCDD, 5'd14, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
      vecs[16] = mk(3'd6, 2'd3, 32'hAABB_CCDD, 5'd15, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_allowin",   32'(ws_allowin),        32'd1);
      check("rst_rf_wen",    32'(rf_wen),            32'd0);
      check("rst_rf_waddr",  32'(rf_waddr),          32'd0);
      check("rst_rf_wdata",  rf_wdata,               32'd0);
      check("rst_fwd_valid", 32'(ws_fwd_valid),      32'd0);
      check("rst_fwd_dest",  32'(ws_fwd_dest),       32'd0);
      check("rst_fwd_data",  ws_fwd_data,            32'd0);
      check("rst_dbg_pc",    debug_wb_pc,            32'd0);
      check("rst_dbg_wen",   32'(debug_wb_rf_wen),   32'd0);
      check("rst_dbg_wnum",  32'(debug_wb_rf_wnum),  32'd0);
      check("rst_dbg_wdata", debug_wb_rf_wdata,      32'd0);

      // Vector table: one instruction at a time, checked in its retire cycle
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive_instr(32'h0000_1000 + 32'(i) * 4, vecs[i].gr_we, vecs[i].dest,
                     vecs[i].op, vecs[i].lo, vecs[i].word);
         @(negedge clk);
         idle_input();
         #1;
         check($sformatf("v%0d_rf_wen", i),    32'(rf_wen),          32'(vecs[i].exp_wen));
         check($sformatf("v%0d_dbg_wen", i),   32'(debug_wb_rf_wen), 32'(vecs[i].exp_wen));
         check($sformatf("v%0d_fwd_valid", i), 32'(ws_fwd_valid),    32'(vecs[i].exp_fwd));
         check($sformatf("v%0d_dbg_pc", i),    debug_wb_pc,          32'h0000_1000 + 32'(i) * 4);
         check($sformatf("v%0d_waddr", i),     32'(rf_waddr),        32'(vecs[i].dest));
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d_wdata", i),    rf_wdata,          vecs[i].exp_wdata);
            check($sformatf("v%0d_fwd_data", i), ws_fwd_data,       vecs[i].exp_wdata);
            check($sformatf("v%0d_dbg_wdata", i), debug_wb_rf_wdata, vecs[i].exp_wdata);
         end
         @(negedge clk);
         #1;
         check($sformatf("v%0d_after_wen", i), 32'(rf_wen), 32'd0);
         check($sformatf("v%0d_after_fwd", i), 32'(ws_fwd_valid), 32'd0);
      end

      // Stall: A held three cycles while B is offered, then both retire back to back
      @(negedge clk);
      wb_stall = 1'b1;
      drive_instr(32'h0000_0100, 1'b1, 5'd7, 3'd0, 2'd0, 32'h0000_000A);
      @(negedge clk);
      drive_instr(32'h0000_0104, 1'b1, 5'd8, 3'd0, 2'd0, 32'h0000_000B);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d_allowin", c),  32'(ws_allowin),   32'd0);
         check($sformatf("stall%0d_rf_wen", c),   32'(rf_wen),       32'd0);
         check($sformatf("stall%0d_dbg_pc", c),   debug_wb_pc,       32'h0000_0100);
         check($sformatf("stall%0d_waddr", c),    32'(rf_waddr),     32'd7);
         check($sformatf("stall%0d_wdata", c),    rf_wdata,          32'h0000_000A);
         check($sformatf("stall%0d_fwd_valid", c), 32'(ws_fwd_valid), 32'd1);
         check($sformatf("stall%0d_fwd_dest", c), 32'(ws_fwd_dest),  32'd7);
         @(negedge clk);
      end
      wb_stall = 1'b0;
      #1;
      check("release_allowin", 32'(ws_allowin), 32'd1);
      check("retire_a_wen",    32'(rf_wen),     32'hF);
      check("retire_a_pc",     debug_wb_pc,     32'h0000_0100);
      check("retire_a_wdata",  rf_wdata,        32'h0000_000A);
      @(negedge clk);
      idle_input();
      #1;
      check("retire_b_wen",   32'(rf_wen),   32'hF);
      check("retire_b_pc",    debug_wb_pc,   32'h0000_0104);
      check("retire_b_waddr", 32'(rf_waddr), 32'd8);
      check("retire_b_wdata", rf_wdata,      32'h0000_000B);
      @(negedge clk);
      #1;
      check("drain_wen",     32'(rf_wen),     32'd0);
      check("drain_allowin", 32'(ws_allowin), 32'd1);

      // Reset while an instruction sits in WB
      @(negedge clk);
      drive_instr(32'h0000_0200, 1'b1, 5'd9, 3'd0, 2'd0, 32'h0000_0C0C);
      @(negedge clk);
      idle_input();
      rst = 1'b1;
      #1;
      check("rstmid_wen_same_cycle", 32'(rf_wen), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_wen_after",  32'(rf_wen),       32'd0);
      check("rstmid_allowin",    32'(ws_allowin),   32'd1);
      check("rstmid_fwd_valid",  32'(ws_fwd_valid), 32'd0);
      check("rstmid_dbg_pc",     debug_wb_pc,       32'd0);
      @(negedge clk);
      #1;
      check("rstmid_wen_later",  32'(rf_wen),       32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
